core_hazard_ctrl: RTL and testbench

- Pipeline interlock controller for the in-order core.
- Tracks in-flight register writes in the X, M and W stages with an internal 3-slot scoreboard.
- Drives the decode stage's `stall`, `flush`, `fwd_rs*en` and `fwd_value*` inputs.
- Sequences redirect flushes, serialises CSR instructions by draining the pipeline, and counts stall cycles for performance monitoring.

---
 rtl/core_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_core_hazard_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_hazard_ctrl.sv
// rtl/core_hazard_ctrl.sv - pipeline interlock: X/M/W scoreboard, forwarding, flush sequencing, stall counter
module core_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_valid,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [4:0]       d_rd,
    input  logic             d_reg_wen,
    input  logic             d_mem_ren,
    input  logic             d_is_csr,
    input  logic             d_fire,
    input  logic             x_fire,
    input  logic             m_fire,
    input  logic             w_fire,
    input  logic [31:0]      x_result,
    input  logic [31:0]      m_result,
    input  logic [31:0]      w_result,
    input  logic             m_load_done,
    input  logic             redirect,
    input  logic             perf_clr,
    output logic             stall,
    output logic             flush,
    output logic             fwd_rs1en,
    output logic             fwd_rs2en,
    output logic [31:0]      fwd_value1,
    output logic [31:0]      fwd_value2,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wen;
        logic       load;
    } slot_t;

    typedef struct packed {
        logic        haz;
        logic        en;
        logic [31:0] value;
    } fwd_t;

    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t     state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    slot_t      sx, sm, sw;
    fwd_t       f1, f2;
    logic       capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            fcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // A redirect always restarts the flush window, even mid-flush.
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        if (redirect) begin
            fcnt_nxt  = FLUSH_LOAD;
            state_nxt = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;
        end else if (state == FLUSH) begin
            fcnt_nxt  = (fcnt != 3'd0) ? fcnt - 3'd1 : 3'd0;
            state_nxt = (fcnt <= 3'd1) ? RUN : FLUSH;
        end
    end

    always_comb begin
        flush = redirect | (state == FLUSH);
    end

    assign capture = d_fire & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx <= '0;
            sm <= '0;
            sw <= '0;
        end else begin
            if (m_fire)      sw <= sm;
            else if (w_fire) sw <= '0;
            if (x_fire)      sm <= sx;
            else if (m_fire) sm <= '0;
            if (capture)     sx <= '{v: 1'b1, rd: d_rd, wen: d_reg_wen & (d_rd != 5'd0), load: d_mem_ren};
            else if (x_fire) sx <= '0;
        end
    end

    function automatic logic hit(input slot_t s, input logic [4:0] rs);
        return s.v & s.wen & (s.rd == rs);
    endfunction

    // Youngest producer wins; a load not yet returned is a hazard instead of a forward.
    function automatic fwd_t resolve(input logic use_rs, input logic [4:0] rs,
                                     input slot_t ax, input slot_t am, input slot_t aw,
                                     input logic [31:0] xr, input logic [31:0] mr,
                                     input logic [31:0] wr, input logic mdone);
        fwd_t r;
        r = '0;
        if (use_rs && rs != 5'd0) begin
            if (hit(ax, rs)) begin
                if (ax.load) r.haz = 1'b1;
                else begin r.en = 1'b1; r.value = xr; end
            end else if (hit(am, rs)) begin
                if (am.load && !mdone) r.haz = 1'b1;
                else begin r.en = 1'b1; r.value = mr; end
            end else if (hit(aw, rs)) begin
                r.en = 1'b1;
                r.value = wr;
            end
        end
        return r;
    endfunction

    always_comb begin
        f1 = resolve(d_use_rs1, d_rs1, sx, sm, sw, x_result, m_result, w_result, m_load_done);
        f2 = resolve(d_use_rs2, d_rs2, sx, sm, sw, x_result, m_result, w_result, m_load_done);
    end

    assign fwd_rs1en  = f1.en;
    assign fwd_rs2en  = f2.en;
    assign fwd_value1 = f1.value;
    assign fwd_value2 = f2.value;
    assign busy       = sx.v | sm.v | sw.v;
    assign stall      = d_valid & ~flush & (f1.haz | f2.haz | (d_is_csr & busy));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           stall_cnt <= '0;
        else if (perf_clr)                    stall_cnt <= '0;
        else if (stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
    end

    a_x_into_full_m: assert property (@(posedge clk) disable iff (!rst_n) !(x_fire && sm.v && !m_fire));
    a_m_into_full_w: assert property (@(posedge clk) disable iff (!rst_n) !(m_fire && sw.v && !w_fire));

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// tb/tb_core_hazard_ctrl.sv - self-checking bench for core_hazard_ctrl
module tb_core_hazard_ctrl;

    localparam int FC      = 3;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk, rst_n;
    logic d_valid, d_use_rs1, d_use_rs2, d_reg_wen, d_mem_ren, d_is_csr, d_fire;
    logic [4:0] d_rs1, d_rs2, d_rd;
    logic x_fire, m_fire, w_fire, m_load_done, redirect, perf_clr;
    logic [31:0] x_result, m_result, w_result;
    logic stall, flush, fwd_rs1en, fwd_rs2en, busy;
    logic [31:0] fwd_value1, fwd_value2;
    logic [CW-1:0] stall_cnt;

    core_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_rd(d_rd), .d_reg_wen(d_reg_wen),
        .d_mem_ren(d_mem_ren), .d_is_csr(d_is_csr), .d_fire(d_fire), .x_fire(x_fire),
        .m_fire(m_fire), .w_fire(w_fire), .x_result(x_result), .m_result(m_result),
        .w_result(w_result), .m_load_done(m_load_done), .redirect(redirect), .perf_clr(perf_clr),
        .stall(stall), .flush(flush), .fwd_rs1en(fwd_rs1en), .fwd_rs2en(fwd_rs2en),
        .fwd_value1(fwd_value1), .fwd_value2(fwd_value2), .busy(busy), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: pipeline as an array of in-flight instructions, index 0 = X (youngest).
    typedef struct {bit v; bit [4:0] rd; bit wen; bit load;} mslot_t;
    mslot_t pipe[3];
    int flush_left;
    int scnt;
    logic e_flush, e_stall, e_busy, e_en1, e_en2, e_haz1, e_haz2;
    logic [31:0] e_v1, e_v2;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
        flush_left = 0;
        scnt = 0;
    endtask

    task automatic model_fwd(input logic use_rs, input logic [4:0] rs,
                             output logic en, output logic haz, output logic [31:0] val);
        logic [31:0] res[3];
        res = '{x_result, m_result, w_result};
        en = 0; haz = 0; val = 0;
        if (use_rs && rs != 0) begin
            for (int i = 0; i < 3; i++) begin
                if (pipe[i].v && pipe[i].wen && pipe[i].rd == rs) begin
                    haz = pipe[i].load && (i == 0 || (i == 1 && !m_load_done));
                    en  = !haz;
                    val = haz ? 32'd0 : res[i];
                    break;
                end
            end
        end
    endtask

    task automatic model_eval();
        e_flush = redirect || flush_left > 0;
        e_busy  = pipe[0].v || pipe[1].v || pipe[2].v;
        model_fwd(d_use_rs1, d_rs1, e_en1, e_haz1, e_v1);
        model_fwd(d_use_rs2, d_rs2, e_en2, e_haz2, e_v2);
        e_stall = d_valid && !e_flush && (e_haz1 || e_haz2 || (d_is_csr && e_busy));
    endtask

    task automatic model_update();
        mslot_t nxt[3];
        nxt = pipe;
        if (w_fire) nxt[2].v = 0;
        if (m_fire) begin nxt[2] = pipe[1]; nxt[1].v = 0; end
        if (x_fire) begin nxt[1] = pipe[0]; nxt[0].v = 0; end
        if (d_fire && !e_flush) nxt[0] = '{1, d_rd, d_reg_wen && d_rd != 0, d_mem_ren};
        pipe = nxt;
        if (redirect)            flush_left = FC - 1;
        else if (flush_left > 0) flush_left--;
        if (perf_clr)                       scnt = 0;
        else if (e_stall && scnt < CNT_MAX) scnt++;
    endtask

    // One clock: settle, compare every output to the model, then advance both.
    task automatic tick();
        #1;
        model_eval();
        chk("flush", flush, e_flush);
        chk("stall", stall, e_stall);
        chk("busy", busy, e_busy);
        chk("fwd_rs1en", fwd_rs1en, e_en1);
        chk("fwd_rs2en", fwd_rs2en, e_en2);
        if (!e_haz1) chk("fwd_value1", fwd_value1, e_v1);
        if (!e_haz2) chk("fwd_value2", fwd_value2, e_v2);
        chk("stall_cnt", stall_cnt, scnt);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_valid = 0; d_use_rs1 = 0; d_use_rs2 = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0;
        d_reg_wen = 0; d_mem_ren = 0; d_is_csr = 0; d_fire = 0;
        x_fire = 0; m_fire = 0; w_fire = 0; m_load_done = 0; redirect = 0; perf_clr = 0;
        x_result = 0; m_result = 0; w_result = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic load);
        d_fire = 1; d_rd = rd; d_reg_wen = 1; d_mem_ren = load;
        tick();
        d_fire = 0; d_rd = 0; d_reg_wen = 0; d_mem_ren = 0;
        x_fire = 0; m_fire = 0; w_fire = 0;
    endtask

    task automatic load3(input logic [4:0] rw, input logic lw, input logic [4:0] rm,
                         input logic lm, input logic [4:0] rx, input logic lx);
        issue(rw, lw);
        x_fire = 1; issue(rm, lm);
        x_fire = 1; m_fire = 1; issue(rx, lx);
    endtask

    task automatic drain();
        d_valid = 0; d_fire = 0; redirect = 0;
        x_fire = 1; m_fire = 1; w_fire = 1;
        repeat (3) tick();
        x_fire = 0; m_fire = 0; w_fire = 0;
    endtask

    typedef struct {
        logic [4:0] rw; logic lw; logic [4:0] rm; logic lm; logic [4:0] rx; logic lx;
        logic [4:0] rs1; logic mdone;
        logic exp_en; logic [31:0] exp_val; logic exp_stall;
    } vec_t;
    vec_t vecs[10];

    initial begin
        vecs[0] = '{3, 0, 3, 0, 0, 0, 3, 0, 1, 32'h11, 0};
        vecs[1] = '{3, 0, 0, 0, 0, 0, 3, 0, 1, 32'h22, 0};
        vecs[2] = '{3, 0, 3, 0, 3, 0, 3, 0, 1, 32'h33, 0};
        vecs[3] = '{0, 0, 0, 0, 3, 1, 3, 1, 0, 32'h0, 1};
        vecs[4] = '{0, 0, 3, 1, 0, 0, 3, 0, 0, 32'h0, 1};
        vecs[5] = '{0, 0, 3, 1, 0, 0, 3, 1, 1, 32'h11, 0};
        vecs[6] = '{6, 0, 5, 0, 4, 0, 3, 0, 0, 32'h0, 0};
        vecs[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0};
        vecs[8] = '{0, 0, 3, 0, 5, 1, 3, 0, 1, 32'h11, 0};
        vecs[9] = '{3, 1, 0, 0, 0, 0, 3, 0, 1, 32'h22, 0};

        idle();
        rst_n = 0;
        model_reset();
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_fwd_rs1en", fwd_rs1en, 0);
        chk("rst_fwd_value1", fwd_value1, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // ALU RAW from X
        issue(5, 0);
        d_valid = 1; d_use_rs1 = 1; d_rs1 = 5; x_result = 32'h1234;
        #1;
        chk("raw_x_en", fwd_rs1en, 1);
        chk("raw_x_val", fwd_value1, 32'h1234);
        chk("raw_x_stall", stall, 0);
        tick();
        idle(); drain();

        // Load-use through X then M
        perf_clr = 1; tick(); perf_clr = 0;
        issue(7, 1);
        d_valid = 1; d_use_rs2 = 1; d_rs2 = 7; x_fire = 1;
        #1; chk("lu_x_stall", stall, 1);
        tick(); x_fire = 0;
        #1; chk("lu_m_stall", stall, 1);
        tick();
        m_load_done = 1; m_result = 32'hCAFE;
        #1;
        chk("lu_done_stall", stall, 0);
        chk("lu_done_val", fwd_value2, 32'hCAFE);
        chk("lu_stall_cnt", stall_cnt, 2);
        tick();
        idle(); drain();

        // Writer of x0 never forwards
        issue(0, 0);
        d_valid = 1; d_use_rs1 = 1; d_rs1 = 0; x_result = 32'h55;
        #1; chk("x0_en", fwd_rs1en, 0);
        tick();
        idle(); drain();

        foreach (vecs[i]) begin
            idle();
            load3(vecs[i].rw, vecs[i].lw, vecs[i].rm, vecs[i].lm, vecs[i].rx, vecs[i].lx);
            x_result = 32'h33; m_result = 32'h11; w_result = 32'h22;
            d_valid = 1; d_use_rs1 = 1; d_rs1 = vecs[i].rs1; m_load_done = vecs[i].mdone;
            #1;
            chk($sformatf("vec%0d_en", i), fwd_rs1en, vecs[i].exp_en);
            chk($sformatf("vec%0d_val", i), fwd_value1, vecs[i].exp_val);
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            tick();
            idle(); drain();
        end

        // Flush window: pending load in M, d_fire during flush must not fill X
        issue(7, 1);
        x_fire = 1; tick(); x_fire = 0;
        d_valid = 1; d_use_rs2 = 1; d_rs2 = 7; d_use_rs1 = 1; d_rs1 = 9;
        d_fire = 1; d_rd = 9; d_reg_wen = 1;
        redirect = 1;
        for (int c = 0; c < FC; c++) begin
            #1;
            chk($sformatf("fl%0d_flush", c), flush, 1);
            chk($sformatf("fl%0d_stall", c), stall, 0);
            tick();
            redirect = 0;
        end
        d_fire = 0;
        #1;
        chk("fl_end_flush", flush, 0);
        chk("fl_end_stall", stall, 1);
        chk("fl_x_empty", fwd_rs1en, 0);
        tick();
        idle(); drain();

        // CSR drain
        load3(1, 0, 2, 0, 3, 0);
        d_valid = 1; d_is_csr = 1; x_fire = 1; m_fire = 1; w_fire = 1;
        for (int c = 0; c < 3; c++) begin
            #1; chk($sformatf("csr%0d_stall", c), stall, 1);
            tick();
        end
        x_fire = 0; m_fire = 0; w_fire = 0;
        #1;
        chk("csr_busy", busy, 0);
        chk("csr_stall", stall, 0);
        tick();
        idle();

        // Counter saturation and clear priority
        issue(7, 1);
        d_valid = 1; d_use_rs2 = 1; d_rs2 = 7;
        repeat (CNT_MAX + 5) tick();
        chk("sat_cnt", stall_cnt, CNT_MAX);
        perf_clr = 1; tick(); perf_clr = 0;
        chk("clr_cnt", stall_cnt, 0);
        tick();
        idle(); drain();

        // Reset in the middle of a flush with slots valid
        load3(1, 0, 2, 0, 3, 0);
        d_valid = 1; d_is_csr = 1;
        redirect = 1; tick(); redirect = 0;
        rst_n = 0;
        #1;
        chk("mrst_flush", flush, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_stall", stall, 0);
        chk("mrst_stall_cnt", stall_cnt, 0);
        model_reset();
        #2 rst_n = 1;
        @(posedge clk); #1;
        idle();
        #1; chk("post_rst_flush", flush, 0);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            d_valid   = 1'($urandom);
            d_use_rs1 = 1'($urandom);
            d_use_rs2 = 1'($urandom);
            d_rs1     = 5'($urandom_range(0, 3));
            d_rs2     = 5'($urandom_range(0, 3));
            d_rd      = 5'($urandom_range(0, 3));
            d_reg_wen = 1'($urandom);
            d_mem_ren = 1'($urandom);
            d_is_csr  = ($urandom_range(0, 7) == 0);
            d_fire    = 1'($urandom);
            redirect  = ($urandom_range(0, 9) == 0);
            perf_clr  = ($urandom_range(0, 31) == 0);
            m_load_done = 1'($urandom);
            x_result  = $urandom; m_result = $urandom; w_result = $urandom;
            w_fire = 1'($urandom);
            m_fire = 1'($urandom) && (!pipe[2].v || w_fire);
            x_fire = 1'($urandom) && (!pipe[1].v || m_fire);
            tick();
        end
        idle(); drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
